stim_gen_nx1: RTL

//  Parametrised N-channel write-stimulus generator for the Nx1 multi-input top.

---
 rtl/stim_gen_pkg.sv | 20 ++
 rtl/stim_gen_ch.sv | 97 +++++++++
 rtl/stim_gen_nx1.sv | 81 ++++++++
 3 files changed

// File: rtl/stim_gen_pkg.sv
// Shared types and constants for the N-channel write-stimulus generator.
package stim_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } ch_state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_BURST  = 2'd1;
    localparam logic [1:0] MODE_CONT   = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    // Modes that run a bounded pulse count and can therefore report completion.
    function automatic logic is_finite_mode(input logic [1:0] mode);
        return (mode == MODE_SINGLE) || (mode == MODE_BURST);
    endfunction

endpackage

// File: rtl/stim_gen_ch.sv
// One stimulus channel: counting data, armed resync pair, pulse FSM and pulse counter.
module stim_gen_ch
    import stim_gen_pkg::*;
#(
    parameter int DW      = 8,
    parameter int BURST_W = 8
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic               freeze,
    input  logic               tick,
    input  logic               armed,
    input  logic [1:0]         cfg_mode,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic               wen,
    output logic [DW-1:0]      data,
    output logic               fin
);

    localparam logic [BURST_W-1:0] REM_ONE  = BURST_W'(1);
    localparam logic [BURST_W-1:0] REM_ZERO = BURST_W'(0);

    ch_state_t          state_r;
    logic [1:0]         mode_r;
    logic [BURST_W-1:0] rem_r;
    logic [DW-1:0]      data_r;
    logic               s1_r;
    logic               s2_r;
    logic               wen_r;
    logic               trig_s;

    assign trig_s = s1_r & ~s2_r;

    // Channel state: everything moves only on unfrozen ticks; wen is a one-cycle strobe.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            mode_r  <= MODE_SINGLE;
            rem_r   <= REM_ZERO;
            data_r  <= '0;
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            wen_r   <= 1'b0;
        end else if (freeze) begin
            wen_r <= 1'b0;
        end else begin
            wen_r <= 1'b0;
            if (tick) begin
                data_r <= data_r + DW'(1);
                s1_r   <= armed;
                s2_r   <= s1_r;
                case (state_r)
                    IDLE: begin
                        if (trig_s && (cfg_mode != MODE_OFF)) begin
                            state_r <= ACTIVE;
                            mode_r  <= cfg_mode;
                            if ((cfg_mode == MODE_SINGLE) || (cfg_burst == REM_ZERO)) begin
                                rem_r <= REM_ONE;
                            end else begin
                                rem_r <= cfg_burst;
                            end
                        end
                    end
                    ACTIVE: begin
                        // Continuous runs until the resynced arm drops; no pulse on exit.
                        if (mode_r == MODE_CONT) begin
                            if (!s2_r) begin
                                state_r <= IDLE;
                            end else begin
                                wen_r <= 1'b1;
                            end
                        end else begin
                            wen_r <= 1'b1;
                            rem_r <= rem_r - REM_ONE;
                            if (rem_r == REM_ONE) begin
                                state_r <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        if (!s2_r) begin
                            state_r <= IDLE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign wen  = wen_r;
    assign data = data_r;
    assign fin  = (state_r == DONE) && is_finite_mode(mode_r);

endmodule

// File: rtl/stim_gen_nx1.sv
// N-channel write-stimulus generator: start-delay counter, per-channel generators,
// read-enable loop and completion flag, all in the single clk_i domain.
module stim_gen_nx1
    import stim_gen_pkg::*;
#(
    parameter int NCH     = 9,
    parameter int DW      = 8,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic               freeze,
    input  logic [NCH-1:0]     ch_tick,
    input  logic               rd_tick,
    input  logic [CNT_W-1:0]   cfg_start,
    input  logic [1:0]         cfg_mode,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               valid,
    output logic [NCH-1:0]     wen,
    output logic [NCH*DW-1:0]  data,
    output logic               ren,
    output logic               armed,
    output logic               done
);

    localparam logic [CNT_W-1:0] CYC_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cyc_r;
    logic             armed_r;
    logic             ren_r;
    logic             done_r;
    logic [NCH-1:0]   fin_s;

    // Start-delay counter (saturating), armed compare, read-enable loop and done flag.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cyc_r   <= '0;
            armed_r <= 1'b0;
            ren_r   <= 1'b0;
            done_r  <= 1'b0;
        end else if (freeze) begin
            cyc_r   <= cyc_r;
            armed_r <= armed_r;
            ren_r   <= ren_r;
            done_r  <= done_r;
        end else begin
            if (cyc_r != CYC_MAX) begin
                cyc_r <= cyc_r + CNT_W'(1);
            end
            armed_r <= (cyc_r > cfg_start);
            if (rd_tick) begin
                ren_r <= valid;
            end
            done_r <= &fin_s;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        stim_gen_ch #(
            .DW      (DW),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk_i     (clk_i),
            .reset_n   (reset_n),
            .freeze    (freeze),
            .tick      (ch_tick[k]),
            .armed     (armed_r),
            .cfg_mode  (cfg_mode),
            .cfg_burst (cfg_burst),
            .wen       (wen[k]),
            .data      (data[k*DW +: DW]),
            .fin       (fin_s[k])
        );
    end

    assign armed = armed_r;
    assign ren   = ren_r;
    assign done  = done_r;

endmodule
